// File: rtl/rs_gf16_pkg.sv
// GF(16) arithmetic and shared types for the RS(15,11) key-equation stage.
package rs_gf16_pkg;
  localparam int         SYM_W     = 4;
  localparam logic [4:0] PRIM_POLY = 5'b10011;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DISC, ST_UPD, ST_DONE} bm_state_e;

  typedef struct packed {
    logic [SYM_W-1:0] lambda1;
    logic [SYM_W-1:0] lambda2;
    logic [2:0]       nerr;
    logic             fail;
  } bm_result_t;

  function automatic logic [SYM_W-1:0] gf16_mul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc, sh;
    logic [SYM_W:0]   t;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc ^= sh;
      t = {sh, 1'b0};
      if (t[SYM_W]) t ^= PRIM_POLY;
      sh = t[SYM_W-1:0];
    end
    return acc;
  endfunction

  function automatic logic [SYM_W-1:0] gf16_inv(input logic [SYM_W-1:0] a);
    case (a)
      4'h1: return 4'h1;
      4'h2: return 4'h9;
      4'h3: return 4'hE;
      4'h4: return 4'hD;
      4'h5: return 4'hB;
      4'h6: return 4'h7;
      4'h7: return 4'h6;
      4'h8: return 4'hF;
      4'h9: return 4'h2;
      4'hA: return 4'hC;
      4'hB: return 4'h5;
      4'hC: return 4'hA;
      4'hD: return 4'h4;
      4'hE: return 4'h3;
      4'hF: return 4'h8;
      default: return 4'h0;
    endcase
  endfunction
endpackage

// File: rtl/gf16_mul.sv
// Combinational GF(16) multiplier, p = a*b mod x^4+x+1.
module gf16_mul
  import rs_gf16_pkg::*;
(
  input  logic [SYM_W-1:0] a,
  input  logic [SYM_W-1:0] b,
  output logic [SYM_W-1:0] p
);
  assign p = rs_gf16_pkg::gf16_mul(a, b);
endmodule

// File: rtl/rs_berlekamp_massey.sv
// Berlekamp-Massey key-equation solver: serial syndromes in, error locator Lambda(x) and L out.
module rs_berlekamp_massey #(
  parameter int SYM_W = 4,
  parameter int N_SYN = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [SYM_W-1:0] SYN_IN,
  input  logic             SYN_VALID,
  output logic             SYN_READY,
  output logic [SYM_W-1:0] LAMBDA1,
  output logic [SYM_W-1:0] LAMBDA2,
  output logic [2:0]       NERR,
  output logic             FAIL,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);
  import rs_gf16_pkg::*;

  localparam logic [N_SYN:0][SYM_W-1:0]   LAM_ONE = ((N_SYN+1)*SYM_W)'(1);
  localparam logic [N_SYN-1:0][SYM_W-1:0] B_ONE   = (N_SYN*SYM_W)'(1);

  bm_state_e                   state_q;
  logic [N_SYN-1:0][SYM_W-1:0] syn_q, b_poly_q, dm_b, dm_p, cr_p;
  logic [N_SYN:0][SYM_W-1:0]   lam_q, lam_upd, lam_nx;
  logic [SYM_W-1:0]            b_q, d_q, d_comb, coef;
  logic [2:0]                  l_q, l_nx, m_q;
  logic [1:0]                  r_q, cnt_q;
  logic                        upd_swap;
  bm_result_t                  res_q;

  // Lane i multiplies Lambda_(i+1) by S[r-i]; lanes past r see a zero syndrome.
  always_comb begin
    for (int i = 0; i < N_SYN; i++) begin
      dm_b[i] = '0;
      if (2'(i) < r_q) dm_b[i] = syn_q[r_q - 2'(i) - 2'd1];
    end
  end

  assign coef = rs_gf16_pkg::gf16_mul(d_q, gf16_inv(b_q));

  for (genvar g = 0; g < N_SYN; g++) begin : g_lane
    gf16_mul u_disc (.a(lam_q[g+1]), .b(dm_b[g]),     .p(dm_p[g]));
    gf16_mul u_corr (.a(coef),       .b(b_poly_q[g]), .p(cr_p[g]));
  end

  always_comb begin
    d_comb = syn_q[r_q];
    for (int i = 0; i < N_SYN; i++) d_comb ^= dm_p[i];
  end

  // Correction coef*B shifted up by m; B's x^4 term never lands inside Lambda.
  always_comb begin
    lam_upd = lam_q;
    for (int j = 0; j <= N_SYN; j++)
      for (int k = 0; k < N_SYN; k++)
        if (int'(m_q) + k == j) lam_upd[j] ^= cr_p[k];
    upd_swap = (d_q != '0) && ({l_q, 1'b0} <= {2'b00, r_q});
    lam_nx   = (d_q == '0) ? lam_q : lam_upd;
    l_nx     = upd_swap ? ({1'b0, r_q} + 3'd1 - l_q) : l_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      SYN_READY <= 1'b0;
      OUT_VALID <= 1'b0;
      res_q     <= '0;
      syn_q     <= '0;
      lam_q     <= LAM_ONE;
      b_poly_q  <= B_ONE;
      b_q       <= 4'h1;
      d_q       <= '0;
      l_q       <= '0;
      m_q       <= 3'd1;
      r_q       <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q   <= ST_LOAD;
          SYN_READY <= 1'b1;
        end
        ST_LOAD: if (SYN_VALID) begin
          syn_q[cnt_q] <= SYN_IN;
          cnt_q        <= cnt_q + 2'd1;
          if (cnt_q == 2'(N_SYN-1)) begin
            lam_q     <= LAM_ONE;
            b_poly_q  <= B_ONE;
            b_q       <= 4'h1;
            l_q       <= '0;
            m_q       <= 3'd1;
            r_q       <= '0;
            state_q   <= ST_DISC;
            SYN_READY <= 1'b0;
          end
        end
        ST_DISC: begin
          d_q     <= d_comb;
          state_q <= ST_UPD;
        end
        ST_UPD: begin
          lam_q <= lam_nx;
          l_q   <= l_nx;
          if (upd_swap) begin
            b_poly_q <= lam_q[N_SYN-1:0];
            b_q      <= d_q;
            m_q      <= 3'd1;
          end else begin
            m_q <= m_q + 3'd1;
          end
          if (r_q == 2'(N_SYN-1)) begin
            state_q   <= ST_DONE;
            OUT_VALID <= 1'b1;
            res_q     <= '{lambda1: lam_nx[1], lambda2: lam_nx[2], nerr: l_nx,
                           fail: (l_nx > 3'd2) || (lam_nx[3] != '0) || (lam_nx[4] != '0)};
          end else begin
            r_q     <= r_q + 2'd1;
            state_q <= ST_DISC;
          end
        end
        ST_DONE: if (OUT_READY) begin
          OUT_VALID <= 1'b0;
          state_q   <= ST_LOAD;
          cnt_q     <= '0;
          SYN_READY <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign LAMBDA1 = res_q.lambda1;
  assign LAMBDA2 = res_q.lambda2;
  assign NERR    = res_q.nerr;
  assign FAIL    = res_q.fail;
endmodule
